// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: upstream request handshake, downstream
// result handshake, and the running error count.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ImmExt;
  logic [2:0]  ImmSrc;
  logic [31:0] Base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic        Err;
  logic [7:0]  ErrCnt;

  modport master (
    output in_valid, ImmExt, ImmSrc, Base, out_ready,
    input  in_ready, out_valid, Instr, Err, ErrCnt
  );

  modport slave (
    input  in_valid, ImmExt, ImmSrc, Base, out_ready,
    output in_ready, out_valid, Instr, Err, ErrCnt
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a sign-extended immediate into a RISC-V instruction word and flags
// immediates that do not fit the format; results pass through a 2-entry FIFO.
module imm_encoder (
  input  logic         clk,
  input  logic         reset_n,
  imm_encoder_if.slave bus
);

  // Returns {err, instr}; the immediate fields are written even when err is set.
  function automatic logic [32:0] encode(input logic [31:0] imm,
                                         input logic [2:0]  src,
                                         input logic [31:0] base);
    logic [31:0] instr;
    logic        err;
    instr = base;
    err   = 1'b0;
    case (src)
      3'b000: begin
        instr[31:20] = imm[11:0];
        err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      3'b001: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      3'b010: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
        err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      end
      3'b011: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
        err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      end
      3'b100: begin
        instr[31:12] = imm[31:12];
        err = |imm[11:0];
      end
      default: err = 1'b1;
    endcase
    return {err, instr};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  logic [31:0] instr_p0 [2];
  logic        err_p0   [2];
  logic [1:0]  count_p0;
  logic        rd_ptr_p0;
  logic        wr_ptr_p0;
  logic [7:0]  err_cnt_p0;

  logic        can_accept;
  logic        has_data;
  logic        push;
  logic        pop;
  logic [32:0] enc;

  assign can_accept = (count_p0 != 2'd2);
  assign has_data   = (count_p0 != 2'd0);
  assign push       = bus.in_valid && can_accept;
  assign pop        = has_data && bus.out_ready;
  assign enc        = encode(bus.ImmExt, bus.ImmSrc, bus.Base);

  // Stage p0: FIFO control and error counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_p0   <= 2'd0;
      rd_ptr_p0  <= 1'b0;
      wr_ptr_p0  <= 1'b0;
      err_cnt_p0 <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr_p0 <= ~wr_ptr_p0;
        if (enc[32]) err_cnt_p0 <= sat_inc(err_cnt_p0);
      end
      if (pop) rd_ptr_p0 <= ~rd_ptr_p0;
      case ({push, pop})
        2'b10:   count_p0 <= count_p0 + 2'd1;
        2'b01:   count_p0 <= count_p0 - 2'd1;
        default: count_p0 <= count_p0;
      endcase
    end
  end

  // Stage p0: FIFO storage; stale contents are masked by has_data
  always_ff @(posedge clk) begin
    if (push) begin
      instr_p0[wr_ptr_p0] <= enc[31:0];
      err_p0[wr_ptr_p0]   <= enc[32];
    end
  end

  assign bus.in_ready  = can_accept;
  assign bus.out_valid = has_data;
  assign bus.Instr     = has_data ? instr_p0[rd_ptr_p0] : 32'd0;
  assign bus.Err       = has_data ? err_p0[rd_ptr_p0] : 1'b0;
  assign bus.ErrCnt    = err_cnt_p0;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: reset, per-format packing and error flags,
// backpressure ordering, error-counter saturation and reset while full.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail = 0;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ImmExt    = 32'd0;
    bus.ImmSrc    = 3'd0;
    bus.Base      = 32'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.ErrCnt !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got %0d want 0", bus.ErrCnt); end
    n_checks++;
    if (bus.Instr !== 32'd0 || bus.Err !== 1'b0) begin
      n_fail++; $display("FAIL reset_instr_err got %h/%b want 0/0", bus.Instr, bus.Err);
    end
  endtask

  task automatic test_encode();
    vec_t v [12];
    int   exp_cnt = 0;
    v[0]  = '{32'h00048413, 32'h0000000C, 3'b000, 32'h00C48413, 1'b0};
    v[1]  = '{32'h01E40063, 32'h00000010, 3'b010, 32'h01E40863, 1'b0};
    v[2]  = '{32'h00000AB7, 32'h8CDEF000, 3'b100, 32'h8CDEFAB7, 1'b0};
    v[3]  = '{32'h00002023, 32'hFFFFFFFC, 3'b001, 32'hFE002E23, 1'b0};
    v[4]  = '{32'h0000006F, 32'h00000800, 3'b011, 32'h0010006F, 1'b0};
    v[5]  = '{32'h0000006F, 32'hFFFFFFFE, 3'b011, 32'hFFFFF06F, 1'b0};
    v[6]  = '{32'h00000063, 32'hFFFFFFF0, 3'b010, 32'hFE0008E3, 1'b0};
    v[7]  = '{32'h00000013, 32'h00000800, 3'b000, 32'h80000013, 1'b1};
    v[8]  = '{32'h00000063, 32'h00000003, 3'b010, 32'h00000163, 1'b1};
    v[9]  = '{32'h12345678, 32'hFFFFFFFF, 3'b110, 32'h12345678, 1'b1};
    v[10] = '{32'h0000006F, 32'h00100000, 3'b011, 32'h8000006F, 1'b1};
    v[11] = '{32'h00000037, 32'h00000001, 3'b100, 32'h00000037, 1'b1};
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.Base     = v[i].base;
      bus.ImmExt   = v[i].imm;
      bus.ImmSrc   = v[i].src;
      tick();
      bus.in_valid = 1'b0;
      if (v[i].err) exp_cnt++;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.Instr !== v[i].instr) begin
        n_fail++;
        $display("FAIL encode_instr[%0d] got vld=%b %h want vld=1 %h", i, bus.out_valid, bus.Instr, v[i].instr);
      end
      n_checks++;
      if (bus.Err !== v[i].err) begin
        n_fail++; $display("FAIL encode_err[%0d] got %b want %b", i, bus.Err, v[i].err);
      end
      n_checks++;
      if (bus.ErrCnt !== 8'(exp_cnt)) begin
        n_fail++; $display("FAIL encode_errcnt[%0d] got %0d want %0d", i, bus.ErrCnt, exp_cnt);
      end
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL encode_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [3];
    exp[0] = 32'h00100013;
    exp[1] = 32'h00200013;
    exp[2] = 32'h00300013;
    do_reset();
    bus.out_ready = 1'b0;
    bus.Base      = 32'h00000013;
    bus.ImmSrc    = 3'b000;
    bus.in_valid  = 1'b1;
    bus.ImmExt    = 32'd1;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_1 got %b want 1", bus.in_ready); end
    bus.ImmExt = 32'd2;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after_2 got %b want 0", bus.in_ready); end
    bus.ImmExt = 32'd3;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.Instr !== exp[0]) begin
      n_fail++;
      $display("FAIL bp_hold got rdy=%b vld=%b %h want rdy=0 vld=1 %h", bus.in_ready, bus.out_valid, bus.Instr, exp[0]);
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.Instr !== exp[1] || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got %h rdy=%b want %h rdy=1", bus.Instr, bus.in_ready, exp[1]);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.Instr !== exp[2]) begin
      n_fail++; $display("FAIL bp_third got vld=%b %h want vld=1 %h", bus.out_valid, bus.Instr, exp[2]);
    end
    bus.ImmExt = 32'hDEADBEEF;
    bus.ImmSrc = 3'b111;
    tick();
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.ErrCnt !== 8'd0) begin
      n_fail++; $display("FAIL bp_idle got vld=%b cnt=%0d want vld=0 cnt=0", bus.out_valid, bus.ErrCnt);
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    bus.out_ready = 1'b1;
    bus.Base      = 32'h00000013;
    bus.ImmExt    = 32'd0;
    bus.ImmSrc    = 3'b111;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    n_checks++;
    if (bus.ErrCnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d want 254", bus.ErrCnt); end
    tick();
    n_checks++;
    if (bus.ErrCnt !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d want 255", bus.ErrCnt); end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (bus.ErrCnt !== 8'd255) begin n_fail++; $display("FAIL sat_260 got %0d want 255", bus.ErrCnt); end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_full got vld=%b rdy=%b want vld=1 rdy=0", bus.out_valid, bus.in_ready);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.ErrCnt !== 8'd0 || bus.in_ready !== 1'b1 || bus.Instr !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid got vld=%b cnt=%0d rdy=%b instr=%h want 0/0/1/0", bus.out_valid, bus.ErrCnt, bus.in_ready, bus.Instr);
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept got vld=%b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_backpressure();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
